// File: rtl/multicycle_ctrl_if.sv
// Data-memory handshake between the multicycle controller (master) and memory (slave).
// dmem_req is held high in every MEM cycle; a transfer completes in the cycle where
// dmem_ready is sampled high while dmem_req is high, and dmem_we qualifies it as a write.
interface multicycle_ctrl_if;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (output dmem_req, output dmem_we, input dmem_ready);
  modport slave  (input dmem_req, input dmem_we, output dmem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory-wait timeout, a retired-instruction counter and a latched fault state.
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [5:0]           opcode,
  input  logic                 alu_zero,
  multicycle_ctrl_if.master    dmem,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 reg_we,
  output logic                 reg_dst,
  output logic                 alu_src,
  output logic                 mem_to_reg,
  output logic [5:0]           alu_op,
  output logic                 busy,
  output logic                 fault,
  output logic [CNT_W-1:0]     retired,
  output logic [2:0]           state_dbg
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         opcode_q;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q;
  logic               complete;
  logic               mem_req, mem_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) opcode_q <= opcode;
      if (complete) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    complete   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 6'd0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Decoded from the live opcode; the latched copy drives everything after this.
        case (opcode)
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: state_d = S_EXEC;
          default:                                   state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        alu_op  = opcode_q;
        alu_src = (opcode_q == OP_ADDI) || (opcode_q == OP_LW) || (opcode_q == OP_SW);
        case (opcode_q)
          OP_R, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:  state_d = S_MEM;
          OP_BEQ: begin
            pc_we    = alu_zero;
            pc_src   = 2'b01;
            complete = 1'b1;
          end
          OP_J: begin
            pc_we    = 1'b1;
            pc_src   = 2'b10;
            complete = 1'b1;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode_q == OP_SW);
        if (dmem.dmem_ready) begin
          if (opcode_q == OP_SW) complete = 1'b1;
          else                   state_d  = S_WB;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          // This cycle would be the MEM_TIMEOUT-th without ready.
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (opcode_q == OP_R);
        mem_to_reg = (opcode_q == OP_LW);
        complete   = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) state_d = run ? S_FETCH : S_IDLE;
  end

  assign busy          = (state_q != S_IDLE) && (state_q != S_HALT);
  assign fault         = (state_q == S_HALT);
  assign retired       = retired_q;
  assign state_dbg     = state_q;
  assign dmem.dmem_req = mem_req;
  assign dmem.dmem_we  = mem_we;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-scenario tasks with hand-computed state and
// output-vector sequences, sampled on the falling edge.
module tb_multicycle_ctrl;
  localparam int CNT_W       = 32;
  localparam int MEM_TIMEOUT = 15;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
                         ST_MEM  = 3'd4, ST_WB    = 3'd5, ST_HALT   = 3'd6;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010,
                         OP_BAD = 6'b111111;

  // {ir_we, pc_we, pc_src[1:0], reg_we, reg_dst, alu_src, mem_to_reg, dmem_req, dmem_we, busy, fault}
  localparam logic [11:0] O_IDLE = 12'h000, O_FETCH = 12'hC02, O_DEC  = 12'h002,
                          O_EXR  = 12'h002, O_EXI   = 12'h022, O_BEQT = 12'h502,
                          O_BEQN = 12'h102, O_J     = 12'h602, O_MEML = 12'h00A,
                          O_MEMS = 12'h00E, O_WBR   = 12'h0C2, O_WBI  = 12'h082,
                          O_WBL  = 12'h092, O_HALT  = 12'h001;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run = 1'b0;
  logic [5:0]       opcode = 6'd0;
  logic             alu_zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             ir_we, pc_we, reg_we, reg_dst, alu_src, mem_to_reg, busy, fault;
  logic [1:0]       pc_src;
  logic [5:0]       alu_op;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state_dbg;
  logic [11:0]      outs;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl_if dmem_bus ();
  assign dmem_bus.dmem_ready = mem_ready;

  multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .dmem(dmem_bus.master),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .alu_op(alu_op), .busy(busy),
    .fault(fault), .retired(retired), .state_dbg(state_dbg)
  );

  assign outs = {ir_we, pc_we, pc_src, reg_we, reg_dst, alu_src, mem_to_reg,
                 dmem_bus.dmem_req, dmem_bus.dmem_we, busy, fault};

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; run = 1'b0; opcode = 6'd0; alu_zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if (state_dbg !== ST_IDLE || outs !== O_IDLE || retired !== '0 || alu_op !== 6'd0) begin
      failures++;
      $display("FAIL reset_hold: state=%0d outs=%h retired=%0d alu_op=%h, expected 0/000/0/00",
               state_dbg, outs, retired, alu_op);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (state_dbg !== ST_IDLE || outs !== O_IDLE) begin
        failures++;
        $display("FAIL idle_no_run step %0d: state=%0d outs=%h, expected state=0 outs=000",
                 i, state_dbg, outs);
      end
    end
    run = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (state_dbg !== ST_FETCH || outs !== O_FETCH) begin
      failures++;
      $display("FAIL idle_to_fetch: state=%0d outs=%h, expected state=1 outs=c02", state_dbg, outs);
    end
  endtask

  task automatic test_rtype();
    logic [2:0]  es[5];
    logic [11:0] eo[5];
    es = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_FETCH};
    eo = '{O_FETCH, O_DEC, O_EXR, O_WBR, O_FETCH};
    do_reset();
    opcode = OP_R; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (state_dbg !== es[i] || outs !== eo[i]) begin
        failures++;
        $display("FAIL rtype step %0d: state=%0d outs=%h, expected state=%0d outs=%h",
                 i, state_dbg, outs, es[i], eo[i]);
      end
    end
    checks++;
    if (retired !== 32'd1) begin
      failures++;
      $display("FAIL rtype_retired: got %0d, expected 1", retired);
    end
  endtask

  task automatic test_lw_wait();
    logic [2:0]  es[8];
    logic [11:0] eo[8];
    logic        rd[8];
    es = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_MEM, ST_MEM, ST_WB, ST_FETCH};
    eo = '{O_FETCH, O_DEC, O_EXI, O_MEML, O_MEML, O_MEML, O_WBL, O_FETCH};
    rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    opcode = OP_LW; run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_ready = rd[i];
      #1;
      checks++;
      if (state_dbg !== es[i] || outs !== eo[i]) begin
        failures++;
        $display("FAIL lw_wait step %0d: state=%0d outs=%h, expected state=%0d outs=%h",
                 i, state_dbg, outs, es[i], eo[i]);
      end
    end
    checks++;
    if (retired !== 32'd1) begin
      failures++;
      $display("FAIL lw_retired: got %0d, expected 1", retired);
    end
  endtask

  task automatic test_sw();
    logic [2:0]  es[5];
    logic [11:0] eo[5];
    es = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_FETCH};
    eo = '{O_FETCH, O_DEC, O_EXI, O_MEMS, O_FETCH};
    do_reset();
    opcode = OP_SW; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_ready = (i == 3);
      #1;
      checks++;
      if (state_dbg !== es[i] || outs !== eo[i]) begin
        failures++;
        $display("FAIL sw step %0d: state=%0d outs=%h, expected state=%0d outs=%h",
                 i, state_dbg, outs, es[i], eo[i]);
      end
      if (i == 2) begin
        checks++;
        if (alu_op !== OP_SW) begin
          failures++;
          $display("FAIL sw_alu_op: got %h, expected %h", alu_op, OP_SW);
        end
      end
    end
    checks++;
    if (retired !== 32'd1) begin
      failures++;
      $display("FAIL sw_retired: got %0d, expected 1", retired);
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0]  ops[3];
    logic        zs[3];
    logic [11:0] ex_out[3];
    logic [2:0]  es[4];
    logic [11:0] eo[4];
    ops    = '{OP_BEQ, OP_BEQ, OP_J};
    zs     = '{1'b1, 1'b0, 1'b0};
    ex_out = '{O_BEQT, O_BEQN, O_J};
    es     = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_FETCH};
    for (int k = 0; k < 3; k++) begin
      eo = '{O_FETCH, O_DEC, ex_out[k], O_FETCH};
      do_reset();
      opcode = ops[k]; alu_zero = zs[k]; run = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); #1;
        checks++;
        if (state_dbg !== es[i] || outs !== eo[i]) begin
          failures++;
          $display("FAIL branch%0d step %0d: state=%0d outs=%h, expected state=%0d outs=%h",
                   k, i, state_dbg, outs, es[i], eo[i]);
        end
      end
      checks++;
      if (retired !== 32'd1) begin
        failures++;
        $display("FAIL branch%0d_retired: got %0d, expected 1", k, retired);
      end
    end
  endtask

  task automatic test_timeout();
    logic [2:0] exp_st;
    // Ready never arrives: 15 MEM cycles, then HALT with no retirement.
    do_reset();
    opcode = OP_LW; run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      exp_st = (i == 0) ? ST_FETCH : (i == 1) ? ST_DECODE : (i == 2) ? ST_EXEC :
               (i <= 17) ? ST_MEM : ST_HALT;
      checks++;
      if (state_dbg !== exp_st) begin
        failures++;
        $display("FAIL timeout step %0d: state=%0d, expected %0d", i, state_dbg, exp_st);
      end
    end
    checks++;
    if (outs !== O_HALT || retired !== 32'd0) begin
      failures++;
      $display("FAIL timeout_halt: outs=%h retired=%0d, expected outs=001 retired=0", outs, retired);
    end
    // Ready on the 15th MEM cycle wins over the timeout.
    do_reset();
    opcode = OP_LW; run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = (i == 17);
      #1;
      exp_st = (i == 0) ? ST_FETCH : (i == 1) ? ST_DECODE : (i == 2) ? ST_EXEC :
               (i <= 17) ? ST_MEM : (i == 18) ? ST_WB : ST_FETCH;
      checks++;
      if (state_dbg !== exp_st) begin
        failures++;
        $display("FAIL late_ready step %0d: state=%0d, expected %0d", i, state_dbg, exp_st);
      end
      if (i == 19) begin
        checks++;
        if (retired !== 32'd1 || fault !== 1'b0) begin
          failures++;
          $display("FAIL late_ready_retired: retired=%0d fault=%b, expected 1/0", retired, fault);
        end
      end
    end
  endtask

  task automatic test_bad_opcode();
    logic [2:0]  es[3];
    logic [11:0] eo[3];
    es = '{ST_FETCH, ST_DECODE, ST_HALT};
    eo = '{O_FETCH, O_DEC, O_HALT};
    do_reset();
    opcode = OP_BAD; run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (state_dbg !== es[i] || outs !== eo[i]) begin
        failures++;
        $display("FAIL bad_op step %0d: state=%0d outs=%h, expected state=%0d outs=%h",
                 i, state_dbg, outs, es[i], eo[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = ~run;
      #1;
      checks++;
      if (state_dbg !== ST_HALT || outs !== O_HALT) begin
        failures++;
        $display("FAIL halt_sticky step %0d: state=%0d outs=%h, expected state=6 outs=001",
                 i, state_dbg, outs);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (state_dbg !== ST_IDLE || outs !== O_IDLE) begin
      failures++;
      $display("FAIL halt_reset: state=%0d outs=%h, expected state=0 outs=000", state_dbg, outs);
    end
    rst = 1'b1; run = 1'b1; opcode = OP_R;
    @(negedge clk); #1;
    checks++;
    if (state_dbg !== ST_FETCH) begin
      failures++;
      $display("FAIL halt_restart: state=%0d, expected 1", state_dbg);
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    opcode = OP_R; run = 1'b1;
    // R-type retires, then a lw is left stalled in MEM.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) opcode = OP_LW;
      #1;
    end
    checks++;
    if (state_dbg !== ST_MEM || outs !== O_MEML || retired !== 32'd1) begin
      failures++;
      $display("FAIL pre_reset_mem: state=%0d outs=%h retired=%0d, expected 4/00a/1",
               state_dbg, outs, retired);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE || dmem_bus.dmem_req !== 1'b0 || retired !== 32'd0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL async_reset: outs=%h req=%b retired=%0d state=%0d, expected 000/0/0/0",
               outs, dmem_bus.dmem_req, retired, state_dbg);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (state_dbg !== ST_FETCH || retired !== 32'd0) begin
      failures++;
      $display("FAIL reset_restart: state=%0d retired=%0d, expected 1/0", state_dbg, retired);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  es[10];
    logic [11:0] eo[10];
    es = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB,
           ST_IDLE, ST_IDLE};
    eo = '{O_FETCH, O_DEC, O_EXI, O_WBI, O_FETCH, O_DEC, O_EXR, O_WBR, O_IDLE, O_IDLE};
    do_reset();
    opcode = OP_ADDI; run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) opcode = OP_R;
      if (i == 5) run = 1'b0;
      #1;
      checks++;
      if (state_dbg !== es[i] || outs !== eo[i]) begin
        failures++;
        $display("FAIL b2b step %0d: state=%0d outs=%h, expected state=%0d outs=%h",
                 i, state_dbg, outs, es[i], eo[i]);
      end
      if (i == 2) begin
        checks++;
        if (alu_op !== OP_ADDI) begin
          failures++;
          $display("FAIL b2b_alu_op: got %h, expected %h", alu_op, OP_ADDI);
        end
      end
    end
    checks++;
    if (retired !== 32'd2) begin
      failures++;
      $display("FAIL b2b_retired: got %0d, expected 2", retired);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_branch_jump();
    test_timeout();
    test_bad_opcode();
    test_reset_mid_mem();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
